pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Game-state and ball-physics controller for Pong. It sits directly upstream of the pixel renderer and produces everything the renderer consumes: ball (square) position, ball visibility, both scores, and the startup and game-over flags. It advances once per video frame on a frame_tick pulse. It handles serve delay, wall and paddle bounces, point scoring and win detection.

Parameters:
H_VIDEO, 640, active width in pixels
V_VIDEO, 480, active height in lines
SQ_SIZE, 16, ball side length
PADDLE_W, 12, paddle thickness
PADDLE_H, 96, paddle height
P1_X, 32, paddle 1 left edge x
P2_X, 596, paddle 2 left edge x
BALL_SPEED, 4, pixels per frame on each axis
SERVE_FRAMES, 60, frames the ball is held at centre before moving
WIN_SCORE, 7, score that ends the game (1..15)

Ports:
clk_0  in  1  25.175 MHz pixel clock
rst  in  1  synchronous reset, active-low
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
start_btn  in  1  start button, already synchronised and debounced, level
paddle1_ypos  in  10  paddle 1 top y
paddle2_ypos  in  10  paddle 2 top y
square_xpos  out  10  ball top-left x
square_ypos  out  10  ball top-left y
sq_shown  out  1  ball visible
score_p1  out  4  player 1 score
score_p2  out  4  player 2 score
game_over  out  1  high in OVER state
game_startup  out  1  high in STARTUP state

Behaviour:
- Reset, and clk_0 timing:
  - Reset is rst, synchronous, active-low; clock is clk_0.
  - Reset values: state STARTUP, square_xpos=312, square_ypos=232 (centre = (H_VIDEO-SQ_SIZE)/2, (V_VIDEO-SQ_SIZE)/2), dx=right, dy=down, scores 0, sq_shown 0, game_startup 1, game_over 0, serve_cnt 0, btn_prev 0.
  - Reset mid-operation restores all of these on the next edge. frame_tick is ignored while rst=0.
- All outputs are registered. State, position and scores change only in the cycle after a frame_tick. With no tick, everything holds.
- Start edge: btn_prev samples start_btn on each frame_tick. start_edge = start_btn & ~btn_prev at the tick. The button must be held at least one frame.
- STARTUP:
  - game_startup=1, sq_shown=0.
  - On start_edge: go to SERVE, serve_cnt=SERVE_FRAMES, ball at centre.
- SERVE:
  - sq_shown=1, ball stationary at centre.
  - Each tick decrements serve_cnt. The tick that finds serve_cnt=0 moves to PLAY without moving the ball.
  - The ball therefore first moves on tick SERVE_FRAMES+2 after entry.
- PLAY, each tick, sq_shown=1. Checks use the current position with unsigned 11-bit arithmetic. The x and y rules below are evaluated in the same tick.
  - Y axis:
    - dy=down and y+BALL_SPEED >= V_VIDEO-SQ_SIZE: y=V_VIDEO-SQ_SIZE, dy=up.
    - dy=up and y < BALL_SPEED: y=0, dy=down.
    - Otherwise y moves ±BALL_SPEED.
  - X axis, moving left:
    - Paddle 1 hit: x >= P1_X+PADDLE_W, and x-BALL_SPEED <= P1_X+PADDLE_W, and y+SQ_SIZE > paddle1_ypos, and y < paddle1_ypos+PADDLE_H. Then x=P1_X+PADDLE_W, dx=right.
    - Miss: else if x < BALL_SPEED, score_p2+1 and go to POINT.
    - Otherwise x -= BALL_SPEED.
  - X axis, moving right: mirror of the left case.
    - Paddle 2 face is P2_X-SQ_SIZE. On a hit, x is clamped to that face.
    - Miss when x+SQ_SIZE+BALL_SPEED > H_VIDEO: score_p1+1 and go to POINT.
  - A paddle hit takes priority over a miss in the same tick.
- POINT (lasts one frame):
  - sq_shown=0, ball set to centre.
  - Next tick: if either score = WIN_SCORE, go to OVER.
  - Otherwise go to SERVE with serve_cnt=SERVE_FRAMES and dx pointing toward the player who conceded. dy is unchanged.
- OVER:
  - game_over=1, sq_shown=0, scores hold.
  - On start_edge: scores cleared to 0, go to STARTUP.
- Scores saturate at 15 and never wrap.
- start_btn is ignored in SERVE, PLAY and POINT.

Test Plan:
1. Reset, then start: assert rst=0 for 2 cycles, release → outputs equal the reset values; start_btn=1 across a tick → game_startup=0, sq_shown=1, position (312,232), and position unchanged for 61 ticks.
2. Wall bounce: in PLAY with ball (300,460), dy=down, dx=right → after one tick (304,464), dy=up; next tick (308,460).
3. Paddle-1 hit: paddle1_ypos=200, ball (46,240) moving left → after one tick x=44, dx=right; next tick x=48.
4. Miss: paddle1_ypos=0, ball (2,400) moving left → after one tick score_p2=1, then POINT with sq_shown=0; next tick SERVE at (312,232) with dx=left.
5. Win and restart: score_p1=6, ball at x=621 moving right, paddle2 out of reach → score_p1=7, then game_over=1 on the following tick; start_btn edge → game_startup=1, scores 0.
6. Reset mid-PLAY: assert rst=0 for 1 cycle during PLAY → next edge shows reset values; frame_tick during reset has no effect.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game-state and ball-physics controller: serve delay, wall/paddle bounces,
// scoring and win detection, advancing once per frame_tick.
module pong_game_ctrl #(
  parameter int H_VIDEO      = 640,
  parameter int V_VIDEO      = 480,
  parameter int SQ_SIZE      = 16,
  parameter int PADDLE_W     = 12,
  parameter int PADDLE_H     = 96,
  parameter int P1_X         = 32,
  parameter int P2_X         = 596,
  parameter int BALL_SPEED   = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [9:0] paddle1_ypos,
  input  logic [9:0] paddle2_ypos,
  output logic [9:0] square_xpos,
  output logic [9:0] square_ypos,
  output logic       sq_shown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic       game_startup
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] X_CENTRE = 10'((H_VIDEO - SQ_SIZE) / 2);
  localparam logic [9:0] Y_CENTRE = 10'((V_VIDEO - SQ_SIZE) / 2);
  localparam logic [9:0] Y_BOTTOM = 10'(V_VIDEO - SQ_SIZE);
  localparam logic [9:0] P1_FACE  = 10'(P1_X + PADDLE_W);
  localparam logic [9:0] P2_FACE  = 10'(P2_X - SQ_SIZE);
  localparam logic [9:0] STEP     = 10'(BALL_SPEED);

  localparam logic [10:0] STEP_W     = 11'(BALL_SPEED);
  localparam logic [10:0] SQ_W       = 11'(SQ_SIZE);
  localparam logic [10:0] PAD_H_W    = 11'(PADDLE_H);
  localparam logic [10:0] H_W        = 11'(H_VIDEO);
  localparam logic [10:0] Y_BOTTOM_W = 11'(V_VIDEO - SQ_SIZE);
  localparam logic [10:0] P1_FACE_W  = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] P2_FACE_W  = 11'(P2_X - SQ_SIZE);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
  localparam logic [3:0]       SCORE_MAX  = 4'd15;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  state_t           state_reg, state_next;
  logic [9:0]       x_reg, x_next;
  logic [9:0]       y_reg, y_next;
  logic             dx_right_reg, dx_right_next;
  logic             dy_down_reg, dy_down_next;
  logic [3:0]       score_p1_reg, score_p1_next;
  logic [3:0]       score_p2_reg, score_p2_next;
  logic [CNT_W-1:0] serve_cnt_reg, serve_cnt_next;
  logic             btn_prev_reg, btn_prev_next;
  logic             sq_shown_reg, sq_shown_next;
  logic             game_over_reg, game_over_next;
  logic             game_startup_reg, game_startup_next;

  logic [10:0] x_w, y_w, p1_top, p2_top;
  logic        start_edge, hit1, hit2;

  assign x_w    = {1'b0, x_reg};
  assign y_w    = {1'b0, y_reg};
  assign p1_top = {1'b0, paddle1_ypos};
  assign p2_top = {1'b0, paddle2_ypos};

  assign start_edge = frame_tick & start_btn & ~btn_prev_reg;

  // The x window is one step deep so the ball cannot tunnel through a paddle face.
  assign hit1 = (x_w >= P1_FACE_W) && ((x_w - STEP_W) <= P1_FACE_W) &&
                ((y_w + SQ_W) > p1_top) && (y_w < (p1_top + PAD_H_W));
  assign hit2 = (x_w <= P2_FACE_W) && ((x_w + STEP_W) >= P2_FACE_W) &&
                ((y_w + SQ_W) > p2_top) && (y_w < (p2_top + PAD_H_W));

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state_reg        <= ST_STARTUP;
      x_reg            <= X_CENTRE;
      y_reg            <= Y_CENTRE;
      dx_right_reg     <= 1'b1;
      dy_down_reg      <= 1'b1;
      score_p1_reg     <= 4'd0;
      score_p2_reg     <= 4'd0;
      serve_cnt_reg    <= '0;
      btn_prev_reg     <= 1'b0;
      sq_shown_reg     <= 1'b0;
      game_over_reg    <= 1'b0;
      game_startup_reg <= 1'b1;
    end else begin
      state_reg        <= state_next;
      x_reg            <= x_next;
      y_reg            <= y_next;
      dx_right_reg     <= dx_right_next;
      dy_down_reg      <= dy_down_next;
      score_p1_reg     <= score_p1_next;
      score_p2_reg     <= score_p2_next;
      serve_cnt_reg    <= serve_cnt_next;
      btn_prev_reg     <= btn_prev_next;
      sq_shown_reg     <= sq_shown_next;
      game_over_reg    <= game_over_next;
      game_startup_reg <= game_startup_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    dx_right_next  = dx_right_reg;
    dy_down_next   = dy_down_reg;
    score_p1_next  = score_p1_reg;
    score_p2_next  = score_p2_reg;
    serve_cnt_next = serve_cnt_reg;
    btn_prev_next  = btn_prev_reg;
    if (frame_tick) begin
      btn_prev_next = start_btn;
      case (state_reg)
        ST_STARTUP: begin
          if (start_edge) begin
            state_next     = ST_SERVE;
            serve_cnt_next = SERVE_LOAD;
            x_next         = X_CENTRE;
            y_next         = Y_CENTRE;
          end
        end
        ST_SERVE: begin
          if (serve_cnt_reg == '0) begin
            state_next = ST_PLAY;
          end else begin
            serve_cnt_next = serve_cnt_reg - CNT_ONE;
          end
        end
        ST_PLAY: begin
          if (dy_down_reg) begin
            if ((y_w + STEP_W) >= Y_BOTTOM_W) begin
              y_next       = Y_BOTTOM;
              dy_down_next = 1'b0;
            end else begin
              y_next = y_reg + STEP;
            end
          end else begin
            if (y_w < STEP_W) begin
              y_next       = 10'd0;
              dy_down_next = 1'b1;
            end else begin
              y_next = y_reg - STEP;
            end
          end
          // A miss leaves dx pointing at the conceding side, which is the next serve direction.
          if (!dx_right_reg) begin
            if (hit1) begin
              x_next        = P1_FACE;
              dx_right_next = 1'b1;
            end else if (x_w < STEP_W) begin
              score_p2_next = (score_p2_reg == SCORE_MAX) ? SCORE_MAX : score_p2_reg + 4'd1;
              state_next    = ST_POINT;
              x_next        = X_CENTRE;
              y_next        = Y_CENTRE;
            end else begin
              x_next = x_reg - STEP;
            end
          end else begin
            if (hit2) begin
              x_next        = P2_FACE;
              dx_right_next = 1'b0;
            end else if ((x_w + SQ_W + STEP_W) > H_W) begin
              score_p1_next = (score_p1_reg == SCORE_MAX) ? SCORE_MAX : score_p1_reg + 4'd1;
              state_next    = ST_POINT;
              x_next        = X_CENTRE;
              y_next        = Y_CENTRE;
            end else begin
              x_next = x_reg + STEP;
            end
          end
        end
        ST_POINT: begin
          x_next = X_CENTRE;
          y_next = Y_CENTRE;
          if ((score_p1_reg == WIN) || (score_p2_reg == WIN)) begin
            state_next = ST_OVER;
          end else begin
            state_next     = ST_SERVE;
            serve_cnt_next = SERVE_LOAD;
          end
        end
        ST_OVER: begin
          if (start_edge) begin
            state_next    = ST_STARTUP;
            score_p1_next = 4'd0;
            score_p2_next = 4'd0;
          end
        end
        default: state_next = ST_STARTUP;
      endcase
    end
  end

  // Flags are decoded from the upcoming state so they register alongside it.
  always_comb begin
    sq_shown_next     = (state_next == ST_SERVE) || (state_next == ST_PLAY);
    game_over_next    = (state_next == ST_OVER);
    game_startup_next = (state_next == ST_STARTUP);
  end

  assign square_xpos  = x_reg;
  assign square_ypos  = y_reg;
  assign sq_shown     = sq_shown_reg;
  assign score_p1     = score_p1_reg;
  assign score_p2     = score_p2_reg;
  assign game_over    = game_over_reg;
  assign game_startup = game_startup_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve, wall and paddle bounces, misses,
// a full game to WIN_SCORE, restart and mid-play reset.
module tb_pong_game_ctrl;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic [9:0] paddle1_ypos;
  logic [9:0] paddle2_ypos;
  logic [9:0] square_xpos;
  logic [9:0] square_ypos;
  logic       sq_shown;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic       game_startup;

  int n_checks = 0;
  int n_fail   = 0;

  pong_game_ctrl dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .paddle1_ypos (paddle1_ypos),
    .paddle2_ypos (paddle2_ypos),
    .square_xpos  (square_xpos),
    .square_ypos  (square_ypos),
    .sq_shown     (sq_shown),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .game_over    (game_over),
    .game_startup (game_startup)
  );

  always #20 clk_0 = ~clk_0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("[%0t] %s: observed %0d expected %0d ok", $time, tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(square_xpos), 32'(x));
    check({tag, "_y"}, 32'(square_ypos), 32'(y));
  endtask

  task automatic check_reset_values(input string tag);
    check_ball(tag, 312, 232);
    check({tag, "_shown"}, 32'(sq_shown), 32'd0);
    check({tag, "_startup"}, 32'(game_startup), 32'd1);
    check({tag, "_over"}, 32'(game_over), 32'd0);
    check({tag, "_p1"}, 32'(score_p1), 32'd0);
    check({tag, "_p2"}, 32'(score_p2), 32'd0);
  endtask

  // One frame pulse; returns on a falling edge after the update is visible.
  task automatic tick();
    @(negedge clk_0);
    frame_tick = 1'b1;
    @(negedge clk_0);
    frame_tick = 1'b0;
    @(negedge clk_0);
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  initial begin
    paddle1_ypos = 10'd1000;
    paddle2_ypos = 10'd400;

    // Reset and start
    repeat (2) @(posedge clk_0);
    @(negedge clk_0);
    rst = 1'b1;
    @(negedge clk_0);
    check_reset_values("reset");

    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check("start_startup", 32'(game_startup), 32'd0);
    check("start_shown", 32'(sq_shown), 32'd1);
    check_ball("serve_entry", 312, 232);
    tick_n(60);
    check_ball("serve_60", 312, 232);
    tick();
    check_ball("serve_61", 312, 232);
    tick();
    check_ball("first_move", 316, 236);
    repeat (5) @(negedge clk_0);
    check_ball("no_tick_hold", 316, 236);

    // Bottom wall bounce
    tick_n(56);
    check_ball("pre_bottom", 540, 460);
    tick();
    check_ball("bottom_clamp", 544, 464);
    tick();
    check_ball("after_bottom", 548, 460);

    // Paddle 2 hit
    tick_n(7);
    check_ball("pre_p2", 576, 432);
    tick();
    check_ball("p2_hit", 580, 428);
    tick();
    check_ball("after_p2", 576, 424);

    // Top wall: y reaches 0 still moving up, turns on the next frame
    tick_n(106);
    check_ball("top_reach", 152, 0);
    tick();
    check_ball("top_turn", 148, 0);
    tick();
    check_ball("after_top", 144, 4);

    // Paddle 1 out of reach: player 2 scores
    tick_n(36);
    check_ball("pre_miss_left", 0, 148);
    tick();
    check("miss_left_p2", 32'(score_p2), 32'd1);
    check("miss_left_p1", 32'(score_p1), 32'd0);
    check("point_shown", 32'(sq_shown), 32'd0);
    tick();
    check("reserve_shown", 32'(sq_shown), 32'd1);
    check_ball("reserve_centre", 312, 232);

    // Rally 2 serves left; paddle 1 returns, paddle 2 misses
    paddle1_ypos = 10'd400;
    paddle2_ypos = 10'd1000;
    tick_n(61);
    tick();
    check_ball("serve_left", 308, 236);
    tick_n(57);
    check_ball("r2_bottom", 80, 464);
    tick_n(8);
    check_ball("pre_p1", 48, 432);
    tick();
    check_ball("p1_hit", 44, 428);
    tick();
    check_ball("after_p1", 48, 424);
    tick_n(144);
    check_ball("pre_miss_right", 624, 148);
    tick();
    check("miss_right_p1", 32'(score_p1), 32'd1);
    check("miss_right_p2", 32'(score_p2), 32'd1);
    check("point2_shown", 32'(sq_shown), 32'd0);

    // Player 1 scores out to the win
    for (int i = 2; i <= 7; i++) begin
      tick();
      tick_n(61);
      tick_n(78);
      check($sformatf("rally%0d_x", i), 32'(square_xpos), 32'd624);
      tick();
      check($sformatf("rally%0d_p1", i), 32'(score_p1), 32'(i));
      check($sformatf("rally%0d_over", i), 32'(game_over), 32'd0);
    end
    tick();
    check("over_flag", 32'(game_over), 32'd1);
    check("over_shown", 32'(sq_shown), 32'd0);
    check("over_p1", 32'(score_p1), 32'd7);
    check("over_p2", 32'(score_p2), 32'd1);
    tick();
    check("over_hold", 32'(game_over), 32'd1);

    // Restart from OVER
    start_btn = 1'b1;
    tick();
    check("restart_startup", 32'(game_startup), 32'd1);
    check("restart_over", 32'(game_over), 32'd0);
    check("restart_p1", 32'(score_p1), 32'd0);
    check("restart_p2", 32'(score_p2), 32'd0);
    tick();
    check("held_btn_no_edge", 32'(game_startup), 32'd1);
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check("second_start", 32'(game_startup), 32'd0);
    tick_n(64);
    check("in_play_shown", 32'(sq_shown), 32'd1);

    // Reset mid-PLAY with a frame tick and button press during reset
    @(negedge clk_0);
    rst = 1'b0;
    frame_tick = 1'b1;
    start_btn = 1'b1;
    @(negedge clk_0);
    rst = 1'b1;
    frame_tick = 1'b0;
    check_reset_values("mid_reset");
    tick();
    start_btn = 1'b0;
    check("post_reset_start", 32'(game_startup), 32'd0);
    tick_n(61);
    tick();
    check_ball("post_reset_move", 316, 236);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
